// File: rtl/fcw_sweep_ctrl_if.sv
// fcw_sweep_ctrl_if: host-side bundle of the frequency-sweep controller.
// master: drives start/abort/mode/f_start/f_stop/f_step/dwell.
// slave : drives Fcw/busy/done/dir back to the host and the NCO.
interface fcw_sweep_ctrl_if #(
    parameter int FCW_W   = 36,
    parameter int DWELL_W = 16
);
    logic               start;
    logic               abort;
    logic [1:0]         mode;
    logic [FCW_W-1:0]   f_start;
    logic [FCW_W-1:0]   f_stop;
    logic [FCW_W-1:0]   f_step;
    logic [DWELL_W-1:0] dwell;
    logic [FCW_W-1:0]   Fcw;
    logic               busy;
    logic               done;
    logic               dir;

    modport master (
        output start, abort, mode, f_start, f_stop, f_step, dwell,
        input  Fcw, busy, done, dir
    );

    modport slave (
        input  start, abort, mode, f_start, f_stop, f_step, dwell,
        output Fcw, busy, done, dir
    );
endinterface

// File: rtl/fcw_sweep_ctrl.sv
// fcw_sweep_ctrl: stepped linear chirp generator feeding the NCO Fcw.
// Ports: clk, rst_n (async low), bus (slave: config in, Fcw/busy/done/dir out).
module fcw_sweep_ctrl #(
    parameter int FCW_W   = 36,
    parameter int DWELL_W = 16
) (
    input logic             clk,
    input logic             rst_n,
    fcw_sweep_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

    state_t             state, state_n;
    logic [FCW_W-1:0]   fcw, fcw_n;
    logic [DWELL_W-1:0] cnt, cnt_n;
    logic               done_q, done_n;
    logic               load;

    logic [1:0]         mode_q;
    logic [FCW_W-1:0]   start_q, stop_q, step_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               degen_q;

    // One extra bit so sums/differences never wrap.
    logic [FCW_W:0]     up_sum, dn_dif, top_dif, bot_sum;
    logic [FCW_W-1:0]   up_nxt, dn_nxt, top_nxt, bot_nxt;

    assign up_sum  = {1'b0, fcw} + {1'b0, step_q};
    assign up_nxt  = (up_sum >= {1'b0, stop_q}) ? stop_q
                                                : up_sum[FCW_W-1:0];
    assign dn_dif  = {1'b0, fcw} - {1'b0, step_q};
    assign dn_nxt  = (dn_dif[FCW_W] || dn_dif[FCW_W-1:0] <= start_q)
                   ? start_q : dn_dif[FCW_W-1:0];
    assign top_dif = {1'b0, stop_q} - {1'b0, step_q};
    assign top_nxt = (top_dif[FCW_W] || top_dif[FCW_W-1:0] <= start_q)
                   ? start_q : top_dif[FCW_W-1:0];
    assign bot_sum = {1'b0, start_q} + {1'b0, step_q};
    assign bot_nxt = (bot_sum >= {1'b0, stop_q}) ? stop_q
                                                 : bot_sum[FCW_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            fcw     <= '0;
            cnt     <= '0;
            done_q  <= 1'b0;
            mode_q  <= '0;
            start_q <= '0;
            stop_q  <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            degen_q <= 1'b0;
        end else begin
            state  <= state_n;
            fcw    <= fcw_n;
            cnt    <= cnt_n;
            done_q <= done_n;
            if (load) begin
                mode_q  <= bus.mode;
                start_q <= bus.f_start;
                stop_q  <= bus.f_stop;
                step_q  <= bus.f_step;
                dwell_q <= bus.dwell;
                degen_q <= (bus.f_step == '0) ||
                           (bus.f_stop <= bus.f_start);
            end
        end
    end

    always_comb begin
        state_n = state;
        fcw_n   = fcw;
        cnt_n   = cnt;
        done_n  = 1'b0;
        load    = 1'b0;
        if (bus.abort) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        load    = 1'b1;
                        state_n = UP;
                        fcw_n   = bus.f_start;
                        cnt_n   = bus.dwell;
                    end
                end
                UP: begin
                    if (cnt != '0) begin
                        cnt_n = cnt - DWELL_W'(1);
                    end else begin
                        cnt_n = dwell_q;
                        if (degen_q) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                            cnt_n   = '0;
                        end else if (fcw == stop_q) begin
                            unique case (mode_q)
                                2'd1: fcw_n = start_q;
                                2'd2: begin
                                    state_n = DOWN;
                                    fcw_n   = top_nxt;
                                end
                                default: begin
                                    state_n = IDLE;
                                    done_n  = 1'b1;
                                    cnt_n   = '0;
                                end
                            endcase
                        end else begin
                            fcw_n = up_nxt;
                        end
                    end
                end
                DOWN: begin
                    if (cnt != '0) begin
                        cnt_n = cnt - DWELL_W'(1);
                    end else begin
                        cnt_n = dwell_q;
                        if (fcw == start_q) begin
                            state_n = UP;
                            fcw_n   = bot_nxt;
                        end else begin
                            fcw_n = dn_nxt;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign bus.Fcw  = fcw;
    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.dir  = (state == DOWN);
endmodule

// File: tb/tb_fcw_sweep_ctrl.sv
// tb_fcw_sweep_ctrl: directed vector table, hand sequences and random
// sweeps compared against a level-list model of the chirp.
module tb_fcw_sweep_ctrl;
    localparam int     FCW_W   = 36;
    localparam int     DWELL_W = 16;
    localparam int     NC      = 40;
    localparam longint MAXF    = longint'(64'h0000_000F_FFFF_FFFF);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fcw_sweep_ctrl_if #(.FCW_W(FCW_W), .DWELL_W(DWELL_W)) bus ();

    fcw_sweep_ctrl #(.FCW_W(FCW_W), .DWELL_W(DWELL_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]             mode;
        logic [FCW_W-1:0]       fs, fp, fe;
        logic [DWELL_W-1:0]     dw;
        logic [0:9][FCW_W-1:0]  fcw;
        logic [0:9]             busy, done, dir;
    } vec_t;

    vec_t   vecs [8];
    longint e_fcw  [NC];
    bit     e_busy [NC];
    bit     e_done [NC];
    bit     e_dir  [NC];

    function automatic vec_t mk(
        input logic [1:0] m,
        input logic [FCW_W-1:0] fs, fp, fe,
        input logic [DWELL_W-1:0] dw,
        input logic [0:9][FCW_W-1:0] f,
        input logic [0:9] b, d, r
    );
        vec_t v;
        v.mode = m; v.fs = fs; v.fp = fp; v.fe = fe; v.dw = dw;
        v.fcw = f; v.busy = b; v.done = d; v.dir = r;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [FCW_W-1:0] fcw_e,
                         input logic busy_e, done_e, dir_e);
        checks++;
        if (bus.Fcw !== fcw_e || bus.busy !== busy_e ||
            bus.done !== done_e || bus.dir !== dir_e) begin
            errors++;
            $display("FAIL %s: got Fcw=%0d busy=%b done=%b dir=%b, want Fcw=%0d busy=%b done=%b dir=%b",
                     name, bus.Fcw, bus.busy, bus.done, bus.dir,
                     fcw_e, busy_e, done_e, dir_e);
        end
    endtask

    task automatic set_cfg(input logic [1:0] m,
                           input logic [FCW_W-1:0] fs, fp, fe,
                           input logic [DWELL_W-1:0] dw);
        bus.mode = m; bus.f_start = fs; bus.f_step = fp;
        bus.f_stop = fe; bus.dwell = dw;
    endtask

    task automatic scramble_cfg();
        bus.mode    = 2'($urandom);
        bus.f_start = FCW_W'($urandom);
        bus.f_step  = FCW_W'($urandom);
        bus.f_stop  = FCW_W'($urandom);
        bus.dwell   = DWELL_W'($urandom);
    endtask

    task automatic do_abort(input string name, input logic [FCW_W-1:0] hold);
        bus.start = 1'b0;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check(name, hold, 1'b0, 1'b0, 1'b0);
    endtask

    // poke: fire start and scramble config during busy cycles; must be ignored.
    task automatic apply_vec(input vec_t v, input int id, input bit poke);
        set_cfg(v.mode, v.fs, v.fp, v.fe, v.dw);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check($sformatf("vec%0d_p%0d_c%0d", id, poke, k),
                  v.fcw[k], v.busy[k], v.done[k], v.dir[k]);
            if (poke && v.busy[k]) begin
                bus.start = 1'b1;
                scramble_cfg();
            end else begin
                bus.start = 1'b0;
            end
            if (k < 9) tick();
        end
        do_abort($sformatf("vec%0d_abort", id), v.fcw[9]);
    endtask

    // Expected trajectory: list of frequency levels, each held dw+1 cycles.
    task automatic build_model(input int m, input longint fs, fp, fe,
                               input int dw);
        longint lv[$];
        bit     ld[$];
        longint up[$];
        longint dn[$];
        longint v;
        bit     single;
        int     per, last, idx;
        per    = dw + 1;
        single = !(m == 1 || m == 2) || fp == 0 || fe <= fs;
        if (fp == 0 || fe <= fs) begin
            lv.push_back(fs);
            ld.push_back(1'b0);
        end else begin
            v = fs;
            up.push_back(v);
            while (v != fe && up.size() <= NC) begin
                v = (v + fp >= fe) ? fe : v + fp;
                up.push_back(v);
            end
            v = fe;
            while (v != fs && dn.size() <= NC) begin
                v = (v - fp <= fs) ? fs : v - fp;
                dn.push_back(v);
            end
            foreach (up[i]) begin lv.push_back(up[i]); ld.push_back(1'b0); end
            while (!single && lv.size() <= NC) begin
                if (m == 1) begin
                    foreach (up[i]) begin lv.push_back(up[i]); ld.push_back(1'b0); end
                end else begin
                    foreach (dn[i]) begin lv.push_back(dn[i]); ld.push_back(1'b1); end
                    for (int i = 1; i < up.size(); i++) begin
                        lv.push_back(up[i]);
                        ld.push_back(1'b0);
                    end
                end
            end
        end
        last = lv.size();
        for (int k = 0; k < NC; k++) begin
            idx = k / per;
            if (idx < last) begin
                e_fcw[k] = lv[idx]; e_busy[k] = 1'b1;
                e_done[k] = 1'b0;   e_dir[k]  = ld[idx];
            end else begin
                e_fcw[k] = lv[last-1]; e_busy[k] = 1'b0;
                e_done[k] = (k == last * per); e_dir[k] = 1'b0;
            end
        end
    endtask

    task automatic run_random(input int id);
        int     m, dw;
        longint fs, fp, fe;
        logic [FCW_W-1:0] hold;
        m  = int'($urandom_range(0, 3));
        dw = int'($urandom_range(0, 3));
        if ($urandom_range(0, 5) == 0) begin
            fs = MAXF - longint'($urandom_range(0, 99));
            fe = MAXF - longint'($urandom_range(0, 49));
            fp = longint'($urandom_range(0, 69));
        end else begin
            fs = longint'($urandom_range(0, 199));
            fp = longint'($urandom_range(0, 39));
            fe = longint'($urandom_range(0, 299));
        end
        build_model(m, fs, fp, fe, dw);
        set_cfg(m[1:0], fs[FCW_W-1:0], fp[FCW_W-1:0], fe[FCW_W-1:0],
                dw[DWELL_W-1:0]);
        bus.start = 1'b1;
        tick();
        for (int k = 0; k < NC; k++) begin
            check($sformatf("rnd%0d_c%0d", id, k), e_fcw[k][FCW_W-1:0],
                  e_busy[k], e_done[k], e_dir[k]);
            scramble_cfg();
            bus.start = e_busy[k] ? 1'($urandom) : 1'b0;
            if (k < NC - 1) tick();
        end
        hold = e_fcw[NC-1][FCW_W-1:0];
        do_abort($sformatf("rnd%0d_abort", id), hold);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        set_cfg(2'd0, '0, '0, '0, '0);

        vecs[0] = mk(2'd0, 36'd100, 36'd10, 36'd125, 16'd1,
            {36'd100, 36'd100, 36'd110, 36'd110, 36'd120,
             36'd120, 36'd125, 36'd125, 36'd125, 36'd125},
            10'b1111111100, 10'b0000000010, 10'b0000000000);
        vecs[1] = mk(2'd2, 36'd0, 36'd4, 36'd8, 16'd0,
            {36'd0, 36'd4, 36'd8, 36'd4, 36'd0,
             36'd4, 36'd8, 36'd4, 36'd0, 36'd4},
            10'b1111111111, 10'b0000000000, 10'b0001100110);
        vecs[2] = mk(2'd1, 36'd50, 36'd25, 36'd100, 16'd0,
            {36'd50, 36'd75, 36'd100, 36'd50, 36'd75,
             36'd100, 36'd50, 36'd75, 36'd100, 36'd50},
            10'b1111111111, 10'b0000000000, 10'b0000000000);
        vecs[3] = mk(2'd0, 36'hF_FFFF_FFFD, 36'd8, 36'hF_FFFF_FFFF, 16'd0,
            {36'hF_FFFF_FFFD, {9{36'hF_FFFF_FFFF}}},
            10'b1100000000, 10'b0010000000, 10'b0000000000);
        vecs[4] = mk(2'd2, 36'd7, 36'd0, 36'd20, 16'd2,
            {10{36'd7}},
            10'b1110000000, 10'b0001000000, 10'b0000000000);
        vecs[5] = mk(2'd1, 36'd50, 36'd5, 36'd10, 16'd0,
            {10{36'd50}},
            10'b1000000000, 10'b0100000000, 10'b0000000000);
        vecs[6] = mk(2'd3, 36'd10, 36'd7, 36'd24, 16'd0,
            {36'd10, 36'd17, {8{36'd24}}},
            10'b1110000000, 10'b0001000000, 10'b0000000000);
        vecs[7] = mk(2'd2, 36'd10, 36'd30, 36'd25, 16'd1,
            {36'd10, 36'd10, 36'd25, 36'd25, 36'd10,
             36'd10, 36'd25, 36'd25, 36'd10, 36'd10},
            10'b1111111111, 10'b0000000000, 10'b0000110011);

        tick();
        check("reset", '0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        tick();
        check("idle_after_reset", '0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) apply_vec(vecs[i], i, 1'b0);
        apply_vec(vecs[0], 0, 1'b1);
        apply_vec(vecs[1], 1, 1'b1);

        // Abort at Fcw=110, restart right after, then abort+start in IDLE.
        set_cfg(2'd0, 36'd100, 36'd10, 36'd125, 16'd1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("ab_c0", 36'd100, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        check("ab_c2", 36'd110, 1'b1, 1'b0, 1'b0);
        do_abort("ab_hold", 36'd110);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("ab_restart", 36'd100, 1'b1, 1'b0, 1'b0);
        do_abort("ab_hold2", 36'd100);
        bus.f_start = 36'd200;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        check("ab_start_same", 36'd100, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        tick();
        check("ab_still_idle", 36'd100, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset while ramping down in a triangle.
        set_cfg(2'd2, 36'd0, 36'd4, 36'd8, 16'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        check("rst_pre", 36'd4, 1'b1, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_async", '0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        tick();
        check("rst_idle", '0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 25; i++) run_random(i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
